seg_scan_driver: RTL and testbench
==================================

Name: seg_scan_driver

Overview:
- Time-multiplexed scan driver for the 4-digit 7-segment display.
- Generates the 2-bit digit select and the registered page select that steer the BCD digit mux upstream.
- Takes the mux's BCD output back in, decodes it, and drives active-low anodes and segments with an anti-ghosting blank interval.
- Debounces and synchronises the raw page switch; commits page changes only on frame boundaries.

Parameters:
- REFRESH_DIV, 50000: clk cycles per digit slot; must be > BLANK_CYC and >= 2.
- BLANK_CYC, 500: cycles at the start of each slot with all anodes off; must be >= 1.
- DEBOUNCE_CYC, 500000: cycles the synchronised switch must hold a new value before it is accepted.
- LZ_BLANK, 1: 1 = suppress leading zeros on digits 3..1; digit 0 is never suppressed.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- bcd_in  in  4  BCD digit from the mux for the current digit_sel; combinational, valid in the same cycle
- page_sw  in  1  raw, unsynchronised page switch
- dp_mask  in  4  decimal-point enable per digit, 1 = lit
- digit_sel  out  2  digit select to the mux; 3 = leftmost digit
- page_sel  out  1  debounced page select to the mux
- an  out  4  anodes, active low; an[3] = leftmost
- seg  out  7  segments, active low, ordered {g,f,e,d,c,b,a}
- dp  out  1  decimal point, active low
- frame_start  out  1  one-cycle pulse when digit 3's slot begins

Behaviour:
- Reset (async assert, sync release): tick_cnt=0, digit_sel=3, page_sel=1, an=4'b1111, seg=7'h7F, dp=1, frame_start=0, lz_run=1, debounce state cleared, both sync flops=1.
- Prescaler:
  - tick_cnt counts 0..REFRESH_DIV-1 and wraps.
  - On wrap, digit_sel decrements 3→2→1→0→3.
  - Full frame = 4*REFRESH_DIV cycles.
- Slot phases:
  - BLANK while tick_cnt < BLANK_CYC.
  - SHOW for the rest of the slot.
- Output register (all of an/seg/dp registered; 1-cycle latency from bcd_in/digit_sel):
  - BLANK: an=1111, seg=7F, dp=1.
  - SHOW: an = one-hot-low of digit_sel; seg = decode(bcd_in), or 7F if leading-zero suppressed; dp = ~dp_mask[digit_sel].
- Decode:
  - 0-9: standard 7-segment glyphs (0 → 7'h40, 1 → 7'h79, 8 → 7'h00).
  - 10 (A): dash, seg=7'h3F.
  - 11-15: blank, 7F.
- Leading-zero suppression (LZ_BLANK=1):
  - lz_run is set to 1 at the digit 3 slot start.
  - In each SHOW cycle of digits 3..1: if lz_run and bcd_in==0, blank the segments; otherwise clear lz_run.
  - Digit 0 always displays.
  - dp still obeys dp_mask when the segments are blanked.
- Page switch:
  - 2-flop synchroniser feeds a debounce counter.
  - The counter resets whenever the synchronised value equals the accepted value or changes.
  - After DEBOUNCE_CYC stable cycles, the new value sets pending.
  - page_sel takes the pending value only on the cycle digit_sel wraps 0→3, so a frame never mixes pages.
  - A switch bounce shorter than DEBOUNCE_CYC is ignored.
- frame_start is asserted in the cycle after the 0→3 wrap, coincident with digit_sel=3 and tick_cnt=0.
- Reset mid-slot: all outputs return to reset values immediately (asynchronously); the scan restarts at digit 3.
- Simultaneous debounce acceptance and frame wrap in the same cycle: page_sel updates on that wrap.

Decomposition:
- Shared package holds:
  - seven-segment glyph constants (SEG_0..SEG_9, SEG_DASH, SEG_OFF);
  - anode-off constant;
  - digit index constants (DIG_LEFT=3, DIG_RIGHT=0).
- One natural sub-module: switch_debounce (synchroniser plus counter, parameter DEBOUNCE_CYC, pulse-free level output).
- The decode is a function, not a module.

Test Plan (REFRESH_DIV=8, BLANK_CYC=2, DEBOUNCE_CYC=4):
- Reset, then release with bcd_in driven by a model mux returning 1,2,3,4 for digit 3..0 → digit_sel sequence 3,2,1,0 every 8 cycles; an 1111 for 2 cycles then 0111/1011/1101/1110; seg 79,24,30,19 one cycle after digit_sel.
- Mux returns 0,0,5,0 with LZ_BLANK=1 → digits 3,2 seg=7F; digit 1 seg=12; digit 0 seg=40.
- page_sw toggles 1→0 mid-frame and holds → page_sel stays 1 until the next 0→3 wrap after 4 stable synchronised cycles, then 0; frame_start pulses at that slot.
- page_sw glitch low for 2 cycles → page_sel unchanged.
- bcd_in=10 and 13 → seg=3F and 7F; dp_mask=4'b0100 → dp=0 only during digit 2 SHOW.
- Assert rst_n low at tick_cnt=5 of digit 1 → outputs at reset values within the same cycle; after release, the scan resumes at digit 3 with a full BLANK phase.

Source files
------------

// File: rtl/seg_scan_driver_pkg.sv
// -----------------------------------------------------------------------------
// seg_scan_driver_pkg
// Shared constants and helpers for the 4-digit 7-segment scan driver.
//   - Seven-segment glyphs, active low, bit order {g,f,e,d,c,b,a}.
//   - Anode-off pattern and digit index constants (3 = leftmost digit).
//   - seg_decode(): BCD/code to glyph translation used by the output stage.
// -----------------------------------------------------------------------------
package seg_scan_driver_pkg;

    localparam logic [6:0] SEG_0    = 7'h40;
    localparam logic [6:0] SEG_1    = 7'h79;
    localparam logic [6:0] SEG_2    = 7'h24;
    localparam logic [6:0] SEG_3    = 7'h30;
    localparam logic [6:0] SEG_4    = 7'h19;
    localparam logic [6:0] SEG_5    = 7'h12;
    localparam logic [6:0] SEG_6    = 7'h02;
    localparam logic [6:0] SEG_7    = 7'h78;
    localparam logic [6:0] SEG_8    = 7'h00;
    localparam logic [6:0] SEG_9    = 7'h10;
    localparam logic [6:0] SEG_DASH = 7'h3F;   // only segment g lit
    localparam logic [6:0] SEG_OFF  = 7'h7F;

    localparam logic [3:0] AN_OFF    = 4'hF;
    localparam logic [1:0] DIG_LEFT  = 2'd3;
    localparam logic [1:0] DIG_RIGHT = 2'd0;

    // Code 10 renders as a dash; codes 11..15 render blank.
    function automatic logic [6:0] seg_decode(input logic [3:0] code);
        logic [6:0] glyph;
        case (code)
            4'd0:    glyph = SEG_0;
            4'd1:    glyph = SEG_1;
            4'd2:    glyph = SEG_2;
            4'd3:    glyph = SEG_3;
            4'd4:    glyph = SEG_4;
            4'd5:    glyph = SEG_5;
            4'd6:    glyph = SEG_6;
            4'd7:    glyph = SEG_7;
            4'd8:    glyph = SEG_8;
            4'd9:    glyph = SEG_9;
            4'd10:   glyph = SEG_DASH;
            default: glyph = SEG_OFF;
        endcase
        return glyph;
    endfunction

endpackage

// File: rtl/seg_scan_driver_switch_debounce.sv
// -----------------------------------------------------------------------------
// switch_debounce
// Two-flop synchroniser followed by a stability counter for a raw switch.
// The accepted level changes only after the synchronised input has differed
// from it for DEBOUNCE_CYC consecutive cycles; shorter bounces are ignored.
// Ports:
//   clk          system clock
//   rst_n        asynchronous active-low reset (all flops return to RESET_VAL)
//   sw_i         raw, unsynchronised switch input
//   level_o      accepted (debounced) level, registered
//   level_next_o value level_o takes at the next edge, so a consumer can act
//                on an acceptance in the same cycle it happens
// -----------------------------------------------------------------------------
module switch_debounce #(
    parameter int   DEBOUNCE_CYC = 500000,
    parameter logic RESET_VAL    = 1'b1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic sw_i,
    output logic level_o,
    output logic level_next_o
);

    localparam int CW = (DEBOUNCE_CYC < 2) ? 1 : $clog2(DEBOUNCE_CYC + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYC - 1);

    logic          sync1_q;
    logic          sync2_q;
    logic          level_q;
    logic          level_d;
    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;
    logic          differ;
    logic          accept;

    always_comb begin
        // With a single-bit level, "differs from accepted" already implies the
        // run was unbroken; any change returns it to the accepted value.
        differ  = (sync2_q != level_q);
        accept  = differ && (cnt_q == CNT_LAST);
        cnt_d   = (differ && !accept) ? cnt_q + 1'b1 : '0;
        level_d = accept ? sync2_q : level_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= RESET_VAL;
            sync2_q <= RESET_VAL;
            level_q <= RESET_VAL;
            cnt_q   <= '0;
        end else begin
            sync1_q <= sw_i;
            sync2_q <= sync1_q;
            level_q <= level_d;
            cnt_q   <= cnt_d;
        end
    end

    assign level_o      = level_q;
    assign level_next_o = level_d;

endmodule

// File: rtl/seg_scan_driver.sv
// -----------------------------------------------------------------------------
// seg_scan_driver
// Time-multiplexed scan driver for a 4-digit 7-segment display. Steps the
// digit select through 3,2,1,0 once per REFRESH_DIV cycles, reads the BCD
// digit back from the upstream mux, and drives registered active-low anodes,
// segments and decimal point. The first BLANK_CYC cycles of each slot keep all
// anodes off to avoid ghosting. Leading zeros on digits 3..1 may be blanked.
// The page switch is debounced and applied only on frame boundaries.
// Ports:
//   clk          system clock
//   rst_n        asynchronous active-low reset
//   bcd_in       BCD digit for the current digit_sel (same-cycle, from mux)
//   page_sw      raw page switch
//   dp_mask      decimal-point enable per digit, 1 = lit
//   digit_sel    digit select to the mux, 3 = leftmost
//   page_sel     debounced page select to the mux
//   an           anodes, active low, an[3] = leftmost
//   seg          segments, active low, {g,f,e,d,c,b,a}
//   dp           decimal point, active low
//   frame_start  one-cycle pulse as digit 3's slot begins
// -----------------------------------------------------------------------------
module seg_scan_driver
    import seg_scan_driver_pkg::*;
#(
    parameter int REFRESH_DIV  = 50000,
    parameter int BLANK_CYC    = 500,
    parameter int DEBOUNCE_CYC = 500000,
    parameter int LZ_BLANK     = 1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] bcd_in,
    input  logic       page_sw,
    input  logic [3:0] dp_mask,
    output logic [1:0] digit_sel,
    output logic       page_sel,
    output logic [3:0] an,
    output logic [6:0] seg,
    output logic       dp,
    output logic       frame_start
);

    localparam int TW = (REFRESH_DIV < 2) ? 1 : $clog2(REFRESH_DIV);
    localparam logic [TW-1:0] TICK_LAST  = TW'(REFRESH_DIV - 1);
    localparam logic [TW-1:0] BLANK_LAST = TW'(BLANK_CYC);

    logic [TW-1:0] tick_cnt_q,    tick_cnt_d;
    logic [1:0]    digit_sel_q,   digit_sel_d;
    logic          page_sel_q,    page_sel_d;
    logic [3:0]    an_q,          an_d;
    logic [6:0]    seg_q,         seg_d;
    logic          dp_q,          dp_d;
    logic          frame_start_q, frame_start_d;
    logic          lz_run_q,      lz_run_d;

    logic          tick_wrap;
    logic          frame_wrap;
    logic          in_blank;
    logic          lz_hit;
    logic          page_level;
    logic          page_level_next;
    logic [3:0]    an_show;

    switch_debounce #(
        .DEBOUNCE_CYC (DEBOUNCE_CYC),
        .RESET_VAL    (1'b1)
    ) u_page_debounce (
        .clk          (clk),
        .rst_n        (rst_n),
        .sw_i         (page_sw),
        .level_o      (page_level),
        .level_next_o (page_level_next)
    );

    // One-hot-low anode pattern for the digit currently selected.
    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_an
            assign an_show[gi] = (digit_sel_q != 2'(gi));
        end
    endgenerate

    always_comb begin
        tick_wrap  = (tick_cnt_q == TICK_LAST);
        frame_wrap = tick_wrap && (digit_sel_q == DIG_RIGHT);
        in_blank   = (tick_cnt_q < BLANK_LAST);

        tick_cnt_d  = tick_wrap ? '0 : tick_cnt_q + 1'b1;
        digit_sel_d = tick_wrap ? digit_sel_q - 2'd1 : digit_sel_q;

        // Blank a zero only while every earlier (more significant) digit of
        // this frame was also zero; the rightmost digit is never blanked.
        lz_hit = (LZ_BLANK != 0) && (digit_sel_q != DIG_RIGHT) &&
                 lz_run_q && (bcd_in == 4'd0);

        an_d     = AN_OFF;
        seg_d    = SEG_OFF;
        dp_d     = 1'b1;
        lz_run_d = lz_run_q;

        // Tick 0 is always inside BLANK, so re-arming here never collides
        // with a SHOW-cycle update below.
        if ((tick_cnt_q == '0) && (digit_sel_q == DIG_LEFT)) begin
            lz_run_d = 1'b1;
        end

        if (!in_blank) begin
            an_d  = an_show;
            seg_d = lz_hit ? SEG_OFF : seg_decode(bcd_in);
            dp_d  = ~dp_mask[digit_sel_q];
            if ((digit_sel_q != DIG_RIGHT) && !lz_hit) begin
                lz_run_d = 1'b0;
            end
        end

        // Use the debouncer's next level so an acceptance landing on the
        // wrap cycle is still applied to the frame that starts now.
        page_sel_d    = frame_wrap ? page_level_next : page_sel_q;
        frame_start_d = frame_wrap;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tick_cnt_q    <= '0;
            digit_sel_q   <= DIG_LEFT;
            page_sel_q    <= 1'b1;
            an_q          <= AN_OFF;
            seg_q         <= SEG_OFF;
            dp_q          <= 1'b1;
            frame_start_q <= 1'b0;
            lz_run_q      <= 1'b1;
        end else begin
            tick_cnt_q    <= tick_cnt_d;
            digit_sel_q   <= digit_sel_d;
            page_sel_q    <= page_sel_d;
            an_q          <= an_d;
            seg_q         <= seg_d;
            dp_q          <= dp_d;
            frame_start_q <= frame_start_d;
            lz_run_q      <= lz_run_d;
        end
    end

    assign digit_sel   = digit_sel_q;
    assign page_sel    = page_sel_q;
    assign an          = an_q;
    assign seg         = seg_q;
    assign dp          = dp_q;
    assign frame_start = frame_start_q;

endmodule

// File: tb/tb_seg_scan_driver.sv
// -----------------------------------------------------------------------------
// tb_seg_scan_driver
// Self-checking bench for seg_scan_driver with REFRESH_DIV=8, BLANK_CYC=2,
// DEBOUNCE_CYC=4, LZ_BLANK=1. A table-driven mux feeds bcd_in back from the
// DUT's digit_sel/page_sel; a reference model derives every expected output
// from the cycle count since reset (slot = n / REFRESH_DIV, etc.).
// -----------------------------------------------------------------------------
module tb_seg_scan_driver;

    localparam int RD = 8;
    localparam int BC = 2;
    localparam int DB = 4;
    localparam int FRAME = 4 * RD;

    logic       clk;
    logic       rst_n;
    logic [3:0] bcd_in;
    logic       page_sw;
    logic [3:0] dp_mask;
    logic [1:0] digit_sel;
    logic       page_sel;
    logic [3:0] an;
    logic [6:0] seg;
    logic       dp;
    logic       frame_start;

    int tests_run;
    int tests_failed;

    // Mux contents, indexed {page, digit}.
    logic [3:0] mux_tab [8];
    logic [6:0] glyph   [16];

    assign bcd_in = mux_tab[{page_sel, digit_sel}];

    seg_scan_driver #(
        .REFRESH_DIV  (RD),
        .BLANK_CYC    (BC),
        .DEBOUNCE_CYC (DB),
        .LZ_BLANK     (1)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .bcd_in      (bcd_in),
        .page_sw     (page_sw),
        .dp_mask     (dp_mask),
        .digit_sel   (digit_sel),
        .page_sel    (page_sel),
        .an          (an),
        .seg         (seg),
        .dp          (dp),
        .frame_start (frame_start)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    int         m_n;        // clock edges since reset release
    int         m_tick;
    int         m_dig;
    int         m_bcd;
    int         m_run;      // consecutive cycles synchronised switch != accepted
    logic       m_lz;       // no nonzero digit shown yet this frame
    logic       m_page;
    logic       m_acc;
    logic       m_s1, m_s2;
    logic       m_sup;
    logic [1:0] e_dig;
    logic [3:0] e_an;
    logic [6:0] e_seg;
    logic       e_dp;
    logic       e_fs;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_n = 0; m_run = 0; m_lz = 1'b1; m_page = 1'b1; m_acc = 1'b1;
            m_s1 = 1'b1; m_s2 = 1'b1;
            e_dig = 2'd3; e_an = 4'hF; e_seg = 7'h7F; e_dp = 1'b1; e_fs = 1'b0;
        end else begin
            m_tick = m_n % RD;
            m_dig  = 3 - (m_n / RD) % 4;
            m_bcd  = int'(mux_tab[m_page * 4 + m_dig]);
            if (m_tick == 0 && m_dig == 3) m_lz = 1'b1;
            if (m_tick < BC) begin
                e_an = 4'hF; e_seg = 7'h7F; e_dp = 1'b1;
            end else begin
                m_sup = (m_dig != 0) && m_lz && (m_bcd == 0);
                if (m_dig != 0 && !m_sup) m_lz = 1'b0;
                e_an  = ~(4'(1) << m_dig);
                e_seg = m_sup ? 7'h7F : glyph[m_bcd];
                e_dp  = ~dp_mask[m_dig];
            end
            if (m_s2 != m_acc) m_run++; else m_run = 0;
            if (m_run == DB) begin m_acc = m_s2; m_run = 0; end
            if ((m_n + 1) % FRAME == 0) m_page = m_acc;
            m_s2 = m_s1;
            m_s1 = page_sw;
            m_n++;
            e_dig = 2'(3 - (m_n / RD) % 4);
            e_fs  = (m_n % FRAME == 0);
        end
    end

    function automatic void set_digits(input logic pg, input int d3, input int d2,
                                       input int d1, input int d0);
        mux_tab[pg * 4 + 3] = 4'(d3);
        mux_tab[pg * 4 + 2] = 4'(d2);
        mux_tab[pg * 4 + 1] = 4'(d1);
        mux_tab[pg * 4 + 0] = 4'(d0);
    endfunction

    // ---------------- tests ----------------
    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        tests_run++;
        if ({digit_sel, page_sel, an, seg, dp, frame_start} !== {2'd3, 1'b1, 4'hF, 7'h7F, 1'b1, 1'b0}) begin
            tests_failed++;
            $display("FAIL reset_state: got ds=%0d pg=%0b an=%b seg=%h dp=%b fs=%b, need ds=3 pg=1 an=1111 seg=7f dp=1 fs=0",
                     digit_sel, page_sel, an, seg, dp, frame_start);
        end
        rst_n = 1'b1;
        $display("[TB] test_reset done");
    endtask

    task automatic test_scan();
        set_digits(1'b1, 1, 2, 3, 4);
        set_digits(1'b0, 9, 8, 7, 6);
        for (int c = 0; c < 2 * FRAME; c++) begin
            @(negedge clk);
            tests_run++;
            if ({digit_sel, page_sel, an, seg, dp, frame_start} !== {e_dig, m_page, e_an, e_seg, e_dp, e_fs}) begin
                tests_failed++;
                $display("FAIL scan cyc %0d: got ds=%0d pg=%b an=%b seg=%h dp=%b fs=%b, need ds=%0d pg=%b an=%b seg=%h dp=%b fs=%b",
                         m_n, digit_sel, page_sel, an, seg, dp, frame_start, e_dig, m_page, e_an, e_seg, e_dp, e_fs);
            end
        end
        $display("[TB] test_scan done");
    endtask

    task automatic test_lz();
        set_digits(1'b1, 0, 0, 5, 0);
        for (int c = 0; c < 2 * FRAME; c++) begin
            @(negedge clk);
            tests_run++;
            if ({digit_sel, page_sel, an, seg, dp, frame_start} !== {e_dig, m_page, e_an, e_seg, e_dp, e_fs}) begin
                tests_failed++;
                $display("FAIL lz cyc %0d: got ds=%0d an=%b seg=%h dp=%b, need ds=%0d an=%b seg=%h dp=%b",
                         m_n, digit_sel, an, seg, dp, e_dig, e_an, e_seg, e_dp);
            end
        end
        $display("[TB] test_lz done");
    endtask

    task automatic test_page_switch();
        repeat (9) @(negedge clk);       // mid-frame
        page_sw = 1'b0;
        for (int c = 0; c < 3 * FRAME; c++) begin
            @(negedge clk);
            tests_run++;
            if ({digit_sel, page_sel, an, seg, dp, frame_start} !== {e_dig, m_page, e_an, e_seg, e_dp, e_fs}) begin
                tests_failed++;
                $display("FAIL page_switch cyc %0d: got ds=%0d pg=%b seg=%h fs=%b, need ds=%0d pg=%b seg=%h fs=%b",
                         m_n, digit_sel, page_sel, seg, frame_start, e_dig, m_page, e_seg, e_fs);
            end
        end
        tests_run++;
        if (page_sel !== 1'b0) begin
            tests_failed++;
            $display("FAIL page_switch_final: got page_sel=%b, need 0", page_sel);
        end
        $display("[TB] test_page_switch done");
    endtask

    task automatic test_glitch();
        page_sw = 1'b1;
        repeat (3 * FRAME) @(negedge clk);
        page_sw = 1'b0;
        repeat (2) @(negedge clk);
        page_sw = 1'b1;
        for (int c = 0; c < 2 * FRAME; c++) begin
            @(negedge clk);
            tests_run++;
            if ({digit_sel, page_sel, an, seg, dp, frame_start} !== {e_dig, m_page, e_an, e_seg, e_dp, e_fs}) begin
                tests_failed++;
                $display("FAIL glitch cyc %0d: got pg=%b seg=%h, need pg=%b seg=%h",
                         m_n, page_sel, seg, m_page, e_seg);
            end
        end
        tests_run++;
        if (page_sel !== 1'b1) begin
            tests_failed++;
            $display("FAIL glitch_final: got page_sel=%b, need 1", page_sel);
        end
        $display("[TB] test_glitch done");
    endtask

    task automatic test_dash_dp();
        set_digits(1'b1, 10, 13, 7, 8);
        dp_mask = 4'b0100;
        for (int c = 0; c < 2 * FRAME; c++) begin
            @(negedge clk);
            tests_run++;
            if ({digit_sel, page_sel, an, seg, dp, frame_start} !== {e_dig, m_page, e_an, e_seg, e_dp, e_fs}) begin
                tests_failed++;
                $display("FAIL dash_dp cyc %0d: got an=%b seg=%h dp=%b, need an=%b seg=%h dp=%b",
                         m_n, an, seg, dp, e_an, e_seg, e_dp);
            end
        end
        dp_mask = 4'b0000;
        $display("[TB] test_dash_dp done");
    endtask

    task automatic test_random();
        for (int f = 0; f < 10; f++) begin
            for (int i = 0; i < 8; i++)
                mux_tab[i] = ($urandom_range(0, 2) == 0) ? 4'd0 : 4'($urandom_range(0, 15));
            dp_mask = 4'($urandom_range(0, 15));
            for (int c = 0; c < FRAME; c++) begin
                @(negedge clk);
                tests_run++;
                if ({digit_sel, page_sel, an, seg, dp, frame_start} !== {e_dig, m_page, e_an, e_seg, e_dp, e_fs}) begin
                    tests_failed++;
                    $display("FAIL random cyc %0d: got ds=%0d pg=%b an=%b seg=%h dp=%b fs=%b, need ds=%0d pg=%b an=%b seg=%h dp=%b fs=%b",
                             m_n, digit_sel, page_sel, an, seg, dp, frame_start, e_dig, m_page, e_an, e_seg, e_dp, e_fs);
                end
                if ($urandom_range(0, 5) == 0) page_sw = ~page_sw;
            end
        end
        $display("[TB] test_random done");
    endtask

    task automatic test_reset_mid();
        bit found = 1'b0;
        set_digits(1'b1, 1, 2, 3, 4);
        set_digits(1'b0, 5, 6, 7, 8);
        for (int k = 0; k < 2 * FRAME && !found; k++) begin
            @(negedge clk);
            if ((m_n % RD) == 5 && (3 - (m_n / RD) % 4) == 1) found = 1'b1;
        end
        tests_run++;
        if (!found) begin
            tests_failed++;
            $display("FAIL reset_mid_wait: got no digit-1 tick-5 point within budget, need one");
        end
        rst_n = 1'b0;
        #1;
        tests_run++;
        if ({digit_sel, page_sel, an, seg, dp, frame_start} !== {2'd3, 1'b1, 4'hF, 7'h7F, 1'b1, 1'b0}) begin
            tests_failed++;
            $display("FAIL reset_mid_async: got ds=%0d pg=%b an=%b seg=%h dp=%b fs=%b, need ds=3 pg=1 an=1111 seg=7f dp=1 fs=0",
                     digit_sel, page_sel, an, seg, dp, frame_start);
        end
        page_sw = 1'b1;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        for (int c = 0; c < FRAME + 4; c++) begin
            @(negedge clk);
            tests_run++;
            if ({digit_sel, page_sel, an, seg, dp, frame_start} !== {e_dig, m_page, e_an, e_seg, e_dp, e_fs}) begin
                tests_failed++;
                $display("FAIL reset_mid_resume cyc %0d: got ds=%0d an=%b seg=%h, need ds=%0d an=%b seg=%h",
                         m_n, digit_sel, an, seg, e_dig, e_an, e_seg);
            end
        end
        $display("[TB] test_reset_mid done");
    endtask

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        rst_n        = 1'b0;
        page_sw      = 1'b1;
        dp_mask      = 4'b0000;
        for (int i = 0; i < 8; i++) mux_tab[i] = 4'd0;
        glyph[0]  = 7'h40; glyph[1]  = 7'h79; glyph[2]  = 7'h24; glyph[3]  = 7'h30;
        glyph[4]  = 7'h19; glyph[5]  = 7'h12; glyph[6]  = 7'h02; glyph[7]  = 7'h78;
        glyph[8]  = 7'h00; glyph[9]  = 7'h10; glyph[10] = 7'h3F;
        for (int i = 11; i < 16; i++) glyph[i] = 7'h7F;

        test_reset();
        test_scan();
        test_lz();
        test_page_switch();
        test_glitch();
        test_dash_dp();
        test_random();
        test_reset_mid();

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL timeout: got no completion by 500000 time units, need completion");
        $fatal(1, "timeout");
    end

endmodule
